mdll_r1_fcal: RTL and testbench
===============================

Name: mdll_r1_fcal

Overview:
- Frequency-calibration counter inside mdll_r1, directly downstream of the JTAG debug registers.
- Consumes en_fcal_jtag, fcal_ndiv_ref_jtag and fcal_start_jtag.
- Produces fcal_cnt_2jtag and fcal_ready_2jtag for JTAG readback.
- Counts clk_dco cycles over a window of 2**fcal_ndiv_ref reference periods, using a 4-phase request/acknowledge handshake with the JTAG side.

Parameters:
- N_FCAL_CNT, 10: result counter width.
- N_SYNC, 2: synchronizer depth for the asynchronous inputs (ref clock, start, enable); minimum 2.

Ports:
- clk_dco  input  1  DCO output clock; the only clock of the block.
- rstn  input  1  asynchronous active-low reset.
- clk_refp  input  1  reference clock, treated as asynchronous data and sampled by clk_dco; ref frequency must be at most clk_dco/4.
- en_fcal  input  1  enable fcal mode; asynchronous (JTAG), synchronized internally.
- fcal_ndiv_ref  input  $clog2(N_FCAL_CNT)  window = 2**fcal_ndiv_ref ref periods; quasi-static, sampled on entry to ARM.
- fcal_start  input  1  request; asynchronous, synchronized internally.
- fcal_cnt  output  N_FCAL_CNT  measured clk_dco cycle count.
- fcal_ready  output  1  acknowledge; result valid.

Behaviour:
- Reset (rstn=0, asynchronous): all synchronizer flops 0, state IDLE, fcal_cnt=0, fcal_ready=0, internal counters 0.
- Synchronization:
  - en_s and start_s are N_SYNC-flop synchronized copies of en_fcal and fcal_start.
  - clk_refp passes through N_SYNC flops plus one extra flop.
  - ref_edge = sync_out & ~extra_flop; it is a one-cycle pulse per ref rising edge, with constant latency.
- States: IDLE, ARM, COUNT, DONE.
- IDLE:
  - fcal_ready=0.
  - Go to ARM when en_s & start_s. Latch K = 2**fcal_ndiv_ref.
- ARM:
  - Wait for ref_edge (edge e0).
  - On e0: dco_cnt<=0, ref_cnt<=0, go to COUNT.
- COUNT:
  - dco_cnt increments every cycle, saturating at 2**N_FCAL_CNT-1 (no wrap).
  - On ref_edge: ref_cnt<=ref_cnt+1.
  - When ref_edge occurs with ref_cnt==K-1 (edge e_K): fcal_cnt<=sat(dco_cnt+1), fcal_ready<=1, go to DONE.
  - Result equals the number of clk_dco cycles between the e0 and e_K pulses. With ref period P dco cycles, result = K*P, saturated.
  - ref_cnt width = $clog2(N_FCAL_CNT)+... sized to hold K-1 for the maximum fcal_ndiv_ref.
- DONE:
  - fcal_ready=1 and fcal_cnt held.
  - When start_s=0: go to IDLE; fcal_ready<=0 on that same edge. fcal_cnt keeps its last value.
- Abort:
  - start_s=0 in ARM or COUNT: go to IDLE; fcal_cnt unchanged; fcal_ready stays 0.
  - en_s=0 in any state: go to IDLE, fcal_ready<=0, fcal_cnt<=0. This takes priority over all other transitions.
- Simultaneous events:
  - start_s falling in the same cycle as e_K: abort wins; no result is latched.
- Re-arm: a new measurement starts only after start_s has been seen low (IDLE) and then high again. Holding start high after DONE never triggers a new measurement.
- Latency:
  - fcal_start rise to ARM: N_SYNC+1 cycles.
  - e_K pulse to fcal_ready=1: 1 cycle.
  - fcal_start fall to fcal_ready=0: N_SYNC+1 cycles.
- fcal_ndiv_ref changes after ARM entry are ignored until the next request.

Test Plan:
- Reset, en_fcal=1, fcal_ndiv_ref=2, clk_refp period = 8 clk_dco cycles, pulse fcal_start high -> fcal_ready rises; fcal_cnt=32. Drop start -> fcal_ready=0 after 3 cycles; fcal_cnt stays 32.
- fcal_ndiv_ref=0, ref period 12 -> fcal_cnt=12. Then ndiv=3, second request -> fcal_cnt=96.
- Saturation: N_FCAL_CNT=10, fcal_ndiv_ref=8, ref period 8 (2048 cycles) -> fcal_cnt=1023, fcal_ready=1.
- Abort: start drops mid-COUNT with previous result 32 -> back to IDLE, fcal_ready never rises, fcal_cnt=32. Drop en_fcal instead -> fcal_cnt=0.
- Handshake hold: keep fcal_start high for 1000 cycles after ready -> fcal_cnt stable, no re-measure. Toggle start low then high -> new measurement completes.
- Reset mid-COUNT: assert rstn=0 asynchronously (between clk_dco edges) -> outputs 0 immediately. Release rstn with start held high -> a fresh measurement completes with the correct count.

Source files
------------

// File: rtl/mdll_r1_fcal_if.sv
`default_nettype none
// ============================================================================
// Module      : mdll_r1_fcal_if
// Description : JTAG-side request/acknowledge bundle for the fcal counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdll_r1_fcal_if #(
    parameter int N_FCAL_CNT = 10
);
    localparam int NDW = $clog2(N_FCAL_CNT);

    logic                  en_fcal;
    logic [NDW-1:0]        fcal_ndiv_ref;
    logic                  fcal_start;
    logic [N_FCAL_CNT-1:0] fcal_cnt;
    logic                  fcal_ready;

    modport master (
        output en_fcal, fcal_ndiv_ref, fcal_start,
        input  fcal_cnt, fcal_ready
    );

    modport slave (
        input  en_fcal, fcal_ndiv_ref, fcal_start,
        output fcal_cnt, fcal_ready
    );
endinterface
`default_nettype wire

// File: rtl/mdll_r1_fcal.sv
`default_nettype none
// ============================================================================
// Module      : mdll_r1_fcal
// Description : Counts clk_dco cycles over 2**ndiv reference periods.
// Revision    : 1.0 - initial release
// ============================================================================
module mdll_r1_fcal #(
    parameter int N_FCAL_CNT = 10,
    parameter int N_SYNC     = 2
) (
    input  wire            clk_dco,
    input  wire            rstn,
    input  wire            clk_refp,
    mdll_r1_fcal_if.slave  fcal
);
    localparam int NDW = $clog2(N_FCAL_CNT);
    localparam int RW  = (1 << NDW) - 1;

    typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

    state_t                state, state_nxt;
    logic [N_SYNC-1:0]     en_sync, start_sync, ref_sync;
    logic                  ref_d;
    logic [N_FCAL_CNT-1:0] cnt_q, cnt_nxt;
    logic                  rdy_q, rdy_nxt;
    logic [N_FCAL_CNT-1:0] dco, dco_nxt;
    logic [RW-1:0]         refc, refc_nxt;
    logic [RW-1:0]         km1, km1_nxt;

    logic                  en_s, start_s, ref_edge;
    logic [N_FCAL_CNT-1:0] dco_inc;
    logic [RW-1:0]         ones;

    assign en_s     = en_sync[N_SYNC-1];
    assign start_s  = start_sync[N_SYNC-1];
    assign ref_edge = ref_sync[N_SYNC-1] & ~ref_d;
    assign dco_inc  = (dco == '1) ? dco : dco + N_FCAL_CNT'(1);
    assign ones     = '1;

    always_ff @(posedge clk_dco or negedge rstn) begin
        if (!rstn) begin
            en_sync    <= '0;
            start_sync <= '0;
            ref_sync   <= '0;
            ref_d      <= 1'b0;
            state      <= IDLE;
            cnt_q      <= '0;
            rdy_q      <= 1'b0;
            dco        <= '0;
            refc       <= '0;
            km1        <= '0;
        end else begin
            en_sync    <= {en_sync[N_SYNC-2:0], fcal.en_fcal};
            start_sync <= {start_sync[N_SYNC-2:0], fcal.fcal_start};
            ref_sync   <= {ref_sync[N_SYNC-2:0], clk_refp};
            ref_d      <= ref_sync[N_SYNC-1];
            state      <= state_nxt;
            cnt_q      <= cnt_nxt;
            rdy_q      <= rdy_nxt;
            dco        <= dco_nxt;
            refc       <= refc_nxt;
            km1        <= km1_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        rdy_nxt   = rdy_q;
        dco_nxt   = dco;
        refc_nxt  = refc;
        km1_nxt   = km1;
        if (!en_s) begin
            state_nxt = IDLE;
            rdy_nxt   = 1'b0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    rdy_nxt = 1'b0;
                    if (start_s) begin
                        state_nxt = ARM;
                        // K-1 is a mask of ndiv ones
                        km1_nxt   = ones >> (NDW'(RW) - fcal.fcal_ndiv_ref);
                    end
                end
                ARM: begin
                    if (!start_s) begin
                        state_nxt = IDLE;
                    end else if (ref_edge) begin
                        dco_nxt   = '0;
                        refc_nxt  = '0;
                        state_nxt = COUNT;
                    end
                end
                COUNT: begin
                    if (!start_s) begin
                        state_nxt = IDLE;
                    end else begin
                        dco_nxt = dco_inc;
                        if (ref_edge) begin
                            refc_nxt = refc + RW'(1);
                            if (refc == km1) begin
                                cnt_nxt   = dco_inc;
                                rdy_nxt   = 1'b1;
                                state_nxt = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (!start_s) begin
                        rdy_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign fcal.fcal_cnt   = cnt_q;
    assign fcal.fcal_ready = rdy_q;
endmodule
`default_nettype wire

// File: tb/tb_mdll_r1_fcal.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdll_r1_fcal
// Description : Randomized self-checking bench for mdll_r1_fcal.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdll_r1_fcal;
    localparam int N_FCAL_CNT = 10;
    localparam int N_SYNC     = 2;
    localparam int CNT_MAX    = (1 << N_FCAL_CNT) - 1;

    logic clk_dco  = 1'b0;
    logic rstn     = 1'b0;
    logic clk_refp = 1'b0;
    int   ref_per  = 8;
    int   ref_ph   = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int last_cnt = 0;

    mdll_r1_fcal_if #(.N_FCAL_CNT(N_FCAL_CNT)) fcal ();

    mdll_r1_fcal #(.N_FCAL_CNT(N_FCAL_CNT), .N_SYNC(N_SYNC)) dut (
        .clk_dco  (clk_dco),
        .rstn     (rstn),
        .clk_refp (clk_refp),
        .fcal     (fcal.slave)
    );

    always #5 clk_dco = ~clk_dco;

    // Reference square wave of ref_per dco cycles, phase-locked to clk_dco
    always @(negedge clk_dco) begin
        if (ref_ph >= ref_per - 1) ref_ph = 0;
        else                       ref_ph = ref_ph + 1;
        clk_refp = (ref_ph < ref_per / 2);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_result(input int ndiv, input int per);
        longint r;
        r = (longint'(1) << ndiv) * per;
        return (r > CNT_MAX) ? CNT_MAX : int'(r);
    endfunction

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_dco);
            if (fcal.fcal_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_meas(input int ndiv, input int per, input string tag);
        bit ok;
        int exp;
        @(negedge clk_dco);
        ref_per            = per;
        fcal.fcal_ndiv_ref = 4'(ndiv);
        fcal.fcal_start    = 1'b1;
        exp = model_result(ndiv, per);
        wait_ready(((1 << ndiv) + 4) * per + 50, ok);
        check_eq({tag, "_ready"}, 32'(ok), 32'd1);
        check_eq({tag, "_cnt"}, 32'(fcal.fcal_cnt), 32'(exp));
        last_cnt = exp;
    endtask

    task automatic finish_meas(input string tag);
        @(negedge clk_dco);
        fcal.fcal_start = 1'b0;
        repeat (N_SYNC) @(negedge clk_dco);
        check_eq({tag, "_rdy_hold"}, 32'(fcal.fcal_ready), 32'd1);
        @(negedge clk_dco);
        check_eq({tag, "_rdy_fall"}, 32'(fcal.fcal_ready), 32'd0);
        check_eq({tag, "_cnt_keep"}, 32'(fcal.fcal_cnt), 32'(last_cnt));
    endtask

    initial begin
        bit seen_rdy;
        bit stable;
        bit ok;
        fcal.en_fcal       = 1'b0;
        fcal.fcal_ndiv_ref = '0;
        fcal.fcal_start    = 1'b0;
        repeat (3) @(negedge clk_dco);
        check_eq("rst_cnt", 32'(fcal.fcal_cnt), 32'd0);
        check_eq("rst_rdy", 32'(fcal.fcal_ready), 32'd0);
        rstn         = 1'b1;
        fcal.en_fcal = 1'b1;
        repeat (4) @(negedge clk_dco);

        start_meas(2, 8, "m_2_8");   finish_meas("m_2_8");
        start_meas(0, 12, "m_0_12"); finish_meas("m_0_12");
        start_meas(3, 12, "m_3_12"); finish_meas("m_3_12");
        start_meas(8, 8, "m_sat");   finish_meas("m_sat");

        // Abort by dropping start mid-count keeps the previous result
        start_meas(2, 8, "m_pre"); finish_meas("m_pre");
        @(negedge clk_dco);
        ref_per = 8; fcal.fcal_ndiv_ref = 4'd4; fcal.fcal_start = 1'b1;
        repeat (40) @(negedge clk_dco);
        fcal.fcal_start = 1'b0;
        seen_rdy = 1'b0;
        repeat (200) begin
            @(negedge clk_dco);
            if (fcal.fcal_ready !== 1'b0) seen_rdy = 1'b1;
        end
        check_eq("abort_start_rdy", 32'(seen_rdy), 32'd0);
        check_eq("abort_start_cnt", 32'(fcal.fcal_cnt), 32'(last_cnt));

        // Abort by dropping enable clears the result
        fcal.fcal_start = 1'b1;
        repeat (40) @(negedge clk_dco);
        fcal.en_fcal = 1'b0;
        repeat (N_SYNC + 2) @(negedge clk_dco);
        last_cnt = 0;
        check_eq("abort_en_cnt", 32'(fcal.fcal_cnt), 32'(last_cnt));
        check_eq("abort_en_rdy", 32'(fcal.fcal_ready), 32'd0);
        fcal.fcal_start = 1'b0;
        repeat (4) @(negedge clk_dco);
        fcal.en_fcal = 1'b1;
        repeat (4) @(negedge clk_dco);

        // Holding start high after ready must not re-measure
        start_meas(1, 10, "m_hold");
        ref_per = 6;
        stable = 1'b1;
        repeat (1000) begin
            @(negedge clk_dco);
            if (fcal.fcal_ready !== 1'b1 || fcal.fcal_cnt !== 10'(last_cnt)) stable = 1'b0;
        end
        check_eq("hold_stable", 32'(stable), 32'd1);
        finish_meas("m_hold");
        start_meas(2, 6, "m_rearm"); finish_meas("m_rearm");

        for (int i = 0; i < 8; i++) begin
            int nd, pr;
            nd = $urandom_range(0, 6);
            pr = $urandom_range(4, 20);
            start_meas(nd, pr, $sformatf("rnd%0d", i));
            finish_meas($sformatf("rnd%0d", i));
        end

        // Asynchronous reset mid-count, then a fresh measurement with start held
        @(negedge clk_dco);
        ref_per = 10; fcal.fcal_ndiv_ref = 4'd3; fcal.fcal_start = 1'b1;
        repeat (30) @(negedge clk_dco);
        @(posedge clk_dco);
        #2 rstn = 1'b0;
        #1;
        last_cnt = 0;
        check_eq("arst_cnt", 32'(fcal.fcal_cnt), 32'(last_cnt));
        check_eq("arst_rdy", 32'(fcal.fcal_ready), 32'd0);
        @(negedge clk_dco);
        rstn = 1'b1;
        wait_ready(((1 << 3) + 4) * 10 + 50, ok);
        check_eq("arst_re_ready", 32'(ok), 32'd1);
        last_cnt = model_result(3, 10);
        check_eq("arst_re_cnt", 32'(fcal.fcal_cnt), 32'(last_cnt));
        finish_meas("arst_re");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
